// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial feeder for serial sequence detectors: takes WIDTH-bit words on a
// valid/ready handshake and presents them one bit per clock, with stall and end-of-word flag.
module seq_bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    input  logic             hold,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] shreg_r;
    logic [WIDTH-1:0] shreg_s;
    logic [CW-1:0]    cnt_r;
    logic [CW-1:0]    cnt_s;
    logic             last_s;
    logic             busy_s;
    logic             accept_s;

    // Moves the next bit into the output position, filling the vacated end with zero.
    function automatic logic [WIDTH-1:0] shift_toward_out(input logic [WIDTH-1:0] value);
        if (MSB_FIRST) begin
            return {value[WIDTH-2:0], 1'b0};
        end else begin
            return {1'b0, value[WIDTH-1:1]};
        end
    endfunction

    assign busy_s     = (state_r == SHIFT);
    assign last_s     = (cnt_r == LAST_IDX);
    assign load_ready = rst & ~hold & (~busy_s | last_s);
    assign accept_s   = load_valid & load_ready;
    assign ser_valid  = busy_s & ~hold;
    assign frame_done = rst & busy_s & ~hold & last_s;

    // Serial bit: the output end of the shift register while a word is in flight, else 0.
    always_comb begin
        ser_out = 1'b0;
        if (busy_s) begin
            ser_out = MSB_FIRST ? shreg_r[WIDTH-1] : shreg_r[0];
        end else begin
            ser_out = 1'b0;
        end
    end

    // Next-state logic: load on accept, advance one bit per unstalled cycle, reload at the last bit.
    always_comb begin
        state_s = state_r;
        shreg_s = shreg_r;
        cnt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = SHIFT;
                    shreg_s = load_data;
                    cnt_s   = '0;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (hold) begin
                    state_s = SHIFT;
                end else if (accept_s) begin
                    // only reachable on the last bit, so the next word follows with no bubble
                    shreg_s = load_data;
                    cnt_s   = '0;
                end else if (last_s) begin
                    state_s = IDLE;
                    shreg_s = shift_toward_out(shreg_r);
                    cnt_s   = '0;
                end else begin
                    shreg_s = shift_toward_out(shreg_r);
                    cnt_s   = cnt_r + CW'(1);
                end
            end
            default: begin
                state_s = IDLE;
                shreg_s = '0;
                cnt_s   = '0;
            end
        endcase
    end

    // State registers with synchronous active-low reset; a reset mid-word discards it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= IDLE;
            shreg_r <= '0;
            cnt_r   <= '0;
        end else begin
            state_r <= state_s;
            shreg_r <= shreg_s;
            cnt_r   <= cnt_s;
        end
    end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Directed bench for seq_bit_serializer: reset, MSB/LSB order, back-to-back words,
// stall, mid-word reset and the minimum width.
module tb_seq_bit_serializer;

    logic       clk;
    logic       rst;
    logic       hold;
    logic       lv0, lv1, lv2;
    logic [7:0] data0, data1;
    logic [1:0] data2;
    logic       rdy0, rdy1, rdy2;
    logic       so0, so1, so2;
    logic       sv0, sv1, sv2;
    logic       fd0, fd1, fd2;
    int         errors;
    int         checks;

    seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_dut (
        .clk(clk), .rst(rst), .load_valid(lv0), .load_data(data0), .load_ready(rdy0),
        .hold(hold), .ser_out(so0), .ser_valid(sv0), .frame_done(fd0));

    seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .load_valid(lv1), .load_data(data1), .load_ready(rdy1),
        .hold(hold), .ser_out(so1), .ser_valid(sv1), .frame_done(fd1));

    seq_bit_serializer #(.WIDTH(2), .MSB_FIRST(1'b1)) u_w2 (
        .clk(clk), .rst(rst), .load_valid(lv2), .load_data(data2), .load_ready(rdy2),
        .hold(hold), .ser_out(so2), .ser_valid(sv2), .frame_done(fd2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Checks eight consecutive bits of the 8-bit MSB-first instance, load_valid low.
    task automatic word8(input string tag, input logic [7:0] w);
        logic [7:0] wv;
        wv = w;
        for (int i = 0; i < 8; i++) begin
            mid();
            chk({tag, "_valid"}, 32'(sv0), 32'(1'b1));
            chk({tag, "_out"},   32'(so0), 32'(wv[7-i]));
            chk({tag, "_done"},  32'(fd0), 32'(i == 7));
            chk({tag, "_ready"}, 32'(rdy0), 32'(i == 7));
            next();
        end
    endtask

    initial begin
        logic [15:0] pair;
        logic [7:0]  f0;
        errors = 0;
        checks = 0;
        rst   = 1'b0;
        hold  = 1'b0;
        lv0   = 1'b1;
        lv1   = 1'b0;
        lv2   = 1'b0;
        data0 = 8'hA5;
        data1 = 8'h00;
        data2 = 2'b00;

        // reset held three cycles with a valid word offered
        repeat (3) next();
        mid();
        chk("rst_valid", 32'(sv0), 32'(1'b0));
        chk("rst_out",   32'(so0), 32'(1'b0));
        chk("rst_ready", 32'(rdy0), 32'(1'b0));
        chk("rst_done",  32'(fd0), 32'(1'b0));
        next();
        rst = 1'b1;
        lv0 = 1'b0;
        mid();
        chk("rst_release_ready", 32'(rdy0), 32'(1'b1));

        // single word A5, MSB first
        next();
        lv0   = 1'b1;
        data0 = 8'hA5;
        mid();
        chk("a5_accept_ready", 32'(rdy0), 32'(1'b1));
        next();
        lv0 = 1'b0;
        word8("a5", 8'hA5);
        mid();
        chk("a5_after_valid", 32'(sv0), 32'(1'b0));
        chk("a5_after_out",   32'(so0), 32'(1'b0));

        // back-to-back A5 then 5A with load_valid held
        next();
        lv0   = 1'b1;
        data0 = 8'hA5;
        pair  = 16'hA55A;
        next();
        data0 = 8'h5A;
        for (int i = 0; i < 16; i++) begin
            mid();
            chk("b2b_valid", 32'(sv0), 32'(1'b1));
            chk("b2b_out",   32'(so0), 32'(pair[15-i]));
            chk("b2b_done",  32'(fd0), 32'((i == 7) || (i == 15)));
            chk("b2b_ready", 32'(rdy0), 32'((i % 8) == 7));
            next();
            if (i == 7) lv0 = 1'b0;
        end
        mid();
        chk("b2b_after_valid", 32'(sv0), 32'(1'b0));

        // F0 with a two-cycle stall after three bits
        next();
        lv0   = 1'b1;
        data0 = 8'hF0;
        f0    = 8'hF0;
        next();
        lv0 = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            int k;
            hold = (c == 4) || (c == 5);
            k = (c <= 3) ? c - 1 : ((c >= 6) ? c - 3 : 3);
            mid();
            chk("hold_valid", 32'(sv0), 32'(!((c == 4) || (c == 5))));
            chk("hold_out",   32'(so0), 32'(f0[7-k]));
            chk("hold_done",  32'(fd0), 32'(c == 10));
            chk("hold_ready", 32'(rdy0), 32'(c == 10));
            next();
        end
        hold = 1'b0;
        mid();
        chk("hold_after_valid", 32'(sv0), 32'(1'b0));

        // FF aborted by reset during bit 4, then 81
        next();
        lv0   = 1'b1;
        data0 = 8'hFF;
        next();
        lv0 = 1'b0;
        repeat (3) next();
        rst = 1'b0;
        mid();
        chk("abort_done_in_rst",  32'(fd0), 32'(1'b0));
        chk("abort_ready_in_rst", 32'(rdy0), 32'(1'b0));
        next();
        rst   = 1'b1;
        lv0   = 1'b1;
        data0 = 8'h81;
        mid();
        chk("abort_valid", 32'(sv0), 32'(1'b0));
        chk("abort_out",   32'(so0), 32'(1'b0));
        chk("abort_done",  32'(fd0), 32'(1'b0));
        chk("abort_ready", 32'(rdy0), 32'(1'b1));
        next();
        lv0 = 1'b0;
        word8("w81", 8'h81);

        // LSB-first 01 and WIDTH=2 word 10, loaded together
        lv1   = 1'b1;
        data1 = 8'h01;
        lv2   = 1'b1;
        data2 = 2'b10;
        next();
        lv1 = 1'b0;
        lv2 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            mid();
            chk("lsb_valid", 32'(sv1), 32'(1'b1));
            chk("lsb_out",   32'(so1), 32'(i == 0));
            chk("lsb_done",  32'(fd1), 32'(i == 7));
            chk("w2_valid",  32'(sv2), 32'(i < 2));
            chk("w2_out",    32'(so2), 32'(i == 0));
            chk("w2_done",   32'(fd2), 32'(i == 1));
            chk("w2_ready",  32'(rdy2), 32'(i != 0));
            next();
        end
        mid();
        chk("lsb_after_valid", 32'(sv1), 32'(1'b0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
